// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store controller.
package lsu_pkg;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_SB   = 4'd1,
        OP_SH   = 4'd2,
        OP_SW   = 4'd3,
        OP_LB   = 4'd4,
        OP_LH   = 4'd5,
        OP_LW   = 4'd6,
        OP_LBU  = 4'd7,
        OP_LHU  = 4'd8
    } ls_op_e;

    // Region codes decoded from addr[11:8].
    localparam logic [3:0] REG_DMEM_LO = 4'd0;
    localparam logic [3:0] REG_DMEM_HI = 4'd3;
    localparam logic [3:0] REG_OUT     = 4'd4;
    localparam logic [3:0] REG_IN      = 4'd5;

    typedef logic [1:0] lsu_state_e;
    localparam lsu_state_e IDLE = 2'd0;
    localparam lsu_state_e REQ  = 2'd1;
    localparam lsu_state_e WAIT = 2'd2;
    localparam lsu_state_e RESP = 2'd3;

    function automatic logic is_store(logic [3:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_load(logic [3:0] op);
        return (op >= OP_LB) && (op <= OP_LHU);
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Core request/response bus plus the data-memory port of the load/store controller.
interface lsu_ctrl_if #(
    parameter int unsigned ADDR_W = 12
);
    logic              req_valid;
    logic              req_ready;
    logic              wr_en;
    logic [3:0]        ls_op;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       st_data;
    logic              rsp_valid;
    logic [31:0]       ld_data;
    logic              err;

    logic              dmem_req;
    logic              dmem_we;
    logic [3:0]        dmem_be;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_wdata;
    logic [31:0]       dmem_rdata;
    logic              dmem_rvalid;

    // master: the environment (core request side and data memory).
    modport master (
        output req_valid, wr_en, ls_op, addr, st_data, dmem_rdata, dmem_rvalid,
        input  req_ready, rsp_valid, ld_data, err,
               dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata
    );

    // slave: the controller itself.
    modport slave (
        input  req_valid, wr_en, ls_op, addr, st_data, dmem_rdata, dmem_rvalid,
        output req_ready, rsp_valid, ld_data, err,
               dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata
    );

endinterface

// File: rtl/lsu_lane.sv
// Combinational byte-lane logic: enables, replicated store data, misalignment and
// load extraction/extension.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] st_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        misalign_o,
    output logic [31:0] ld_data_o
);

    logic [15:0] sel_half;

    assign sel_half = 16'(rdata_i >> {offset_i, 3'b000});

    always_comb begin
        be_o       = 4'b0000;
        misalign_o = 1'b0;
        case (op_i)
            OP_SB, OP_LB, OP_LBU: be_o = 4'b0001 << offset_i;
            OP_SH, OP_LH, OP_LHU: begin
                be_o       = offset_i[1] ? 4'b1100 : 4'b0011;
                misalign_o = offset_i[0];
            end
            OP_SW, OP_LW: begin
                be_o       = 4'b1111;
                misalign_o = |offset_i;
            end
            default: ;
        endcase
    end

    always_comb begin
        wdata_o   = st_data_i;
        ld_data_o = 32'd0;
        case (op_i)
            OP_SB:   wdata_o   = {4{st_data_i[7:0]}};
            OP_SH:   wdata_o   = {2{st_data_i[15:0]}};
            OP_LB:   ld_data_o = {{24{sel_half[7]}}, sel_half[7:0]};
            OP_LBU:  ld_data_o = {24'd0, sel_half[7:0]};
            OP_LH:   ld_data_o = {{16{sel_half[15]}}, sel_half};
            OP_LHU:  ld_data_o = {16'd0, sel_half};
            OP_LW:   ld_data_o = rdata_i;
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: one request at a time, routed to external data memory or
// to the local output/input register banks.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned NUM_OUT = 11,
    parameter int unsigned NUM_IN  = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    lsu_ctrl_if.slave             bus,
    input  logic [NUM_IN*32-1:0]  io_in_i,
    output logic [NUM_OUT*32-1:0] io_out_o
);

    lsu_state_e        state_q, state_d;
    logic [3:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       st_data_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic [NUM_OUT-1:0][31:0] out_q;
    logic [NUM_IN-1:0][31:0]  sync1_q, sync2_q;

    logic        idle, accept;
    logic [3:0]  region, idx;
    logic        op_is_st, op_is_ld;
    logic        hit_dmem, hit_out, hit_in, req_err;
    logic [31:0] out_rd, in_rd;
    logic        dmem_active;

    logic [3:0]  cur_op;
    logic [1:0]  cur_off;
    logic [31:0] cur_st;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata, lane_ld;
    logic        lane_misalign;

    assign idle   = (state_q == IDLE);
    assign accept = bus.req_valid & idle;

    // The lane sees the live request while idle and the captured one afterwards.
    assign cur_op  = idle ? bus.ls_op : op_q;
    assign cur_off = idle ? bus.addr[1:0] : addr_q[1:0];
    assign cur_st  = idle ? bus.st_data : st_data_q;

    lsu_lane u_lane (
        .op_i       (cur_op),
        .offset_i   (cur_off),
        .st_data_i  (cur_st),
        .rdata_i    (rdata_q),
        .be_o       (lane_be),
        .wdata_o    (lane_wdata),
        .misalign_o (lane_misalign),
        .ld_data_o  (lane_ld)
    );

    assign region   = bus.addr[11:8];
    assign idx      = bus.addr[7:4];
    assign op_is_st = is_store(bus.ls_op);
    assign op_is_ld = is_load(bus.ls_op);
    assign hit_dmem = (region <= REG_DMEM_HI);
    assign hit_out  = (region == REG_OUT) && ({28'd0, idx} < NUM_OUT);
    assign hit_in   = (region == REG_IN) && ({28'd0, idx} < NUM_IN) && !op_is_st;
    assign req_err  = !(op_is_st | op_is_ld) | (op_is_st != bus.wr_en) | lane_misalign |
                      !(hit_dmem | hit_out | hit_in);

    always_comb begin
        out_rd = 32'd0;
        for (int k = 0; k < int'(NUM_OUT); k++) begin
            if (idx == 4'(k)) out_rd = out_q[k];
        end
    end

    always_comb begin
        in_rd = 32'd0;
        for (int k = 0; k < int'(NUM_IN); k++) begin
            if (idx == 4'(k)) in_rd = sync2_q[k];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = (!req_err && hit_dmem) ? REQ : RESP;
            REQ:  state_d = WAIT;
            WAIT: if (bus.dmem_rvalid) state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            op_q      <= 4'd0;
            addr_q    <= '0;
            st_data_q <= 32'd0;
            rdata_q   <= 32'd0;
            err_q     <= 1'b0;
            out_q     <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
        end else begin
            state_q <= state_d;
            sync1_q <= io_in_i;
            sync2_q <= sync1_q;
            if (accept) begin
                op_q      <= bus.ls_op;
                addr_q    <= bus.addr;
                st_data_q <= bus.st_data;
                err_q     <= req_err;
                rdata_q   <= hit_in ? in_rd : out_rd;
                if (!req_err && hit_out && op_is_st) begin
                    for (int k = 0; k < int'(NUM_OUT); k++) begin
                        for (int b = 0; b < 4; b++) begin
                            if (idx == 4'(k) && lane_be[b]) begin
                                out_q[k][8*b +: 8] <= lane_wdata[8*b +: 8];
                            end
                        end
                    end
                end
            end
            if (state_q == WAIT && bus.dmem_rvalid) rdata_q <= bus.dmem_rdata;
        end
    end

    assign dmem_active = (state_q == REQ) || (state_q == WAIT);

    assign bus.req_ready  = idle;
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.err        = (state_q == RESP) && err_q;
    assign bus.ld_data    = ((state_q == RESP) && !err_q && is_load(op_q)) ? lane_ld : 32'd0;

    assign bus.dmem_req   = (state_q == REQ);
    assign bus.dmem_we    = dmem_active && is_store(op_q);
    assign bus.dmem_be    = dmem_active ? lane_be : 4'b0000;
    assign bus.dmem_addr  = dmem_active ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign bus.dmem_wdata = dmem_active ? lane_wdata : 32'd0;

    assign io_out_o = out_q;

endmodule
